// File: rtl/spi_shift_engine.sv
// Byte-serial SPI master shift core: turns a go edge plus a shadowed word and
// mode into SCLK/MOSI activity, samples MISO and returns the received word.
module spi_shift_engine #(
  parameter int DATA_WIDTH        = 8,
  parameter int CLK_DIVIDER_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         CPOL,
  input  logic                         CPHA,
  input  logic [CLK_DIVIDER_WIDTH-1:0] clk_divider,
  input  logic                         go,
  input  logic [DATA_WIDTH-1:0]        datai,
  output logic [DATA_WIDTH-1:0]        datao,
  output logic                         busy,
  output logic                         done,
  input  logic                         din,
  output logic                         dout,
  output logic                         sclk,
  output logic [1:0]                   dbg_state
);

  localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic                           go_q, go_d;
  logic [DATA_WIDTH-1:0]          tx_q, tx_d;
  logic [DATA_WIDTH-1:0]          rx_q, rx_d;
  logic [DATA_WIDTH-1:0]          datao_q, datao_d;
  logic [CLK_DIVIDER_WIDTH-1:0]   div_q, div_d;
  logic [CLK_DIVIDER_WIDTH-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]                  edge_q, edge_d;
  logic                           cpol_q, cpol_d;
  logic                           cpha_q, cpha_d;
  logic                           sclk_q, sclk_d;
  logic                           dout_q, dout_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           start;
  logic [EW-1:0]                  edge_n;
  logic                           leading;

  // busy_q still high on the cycle after DONE keeps a start out until busy has fallen.
  assign start   = go && !go_q && (state_q == S_IDLE) && !busy_q;
  assign edge_n  = edge_q + 1'b1;
  assign leading = edge_n[0];

  always_comb begin
    state_d = state_q;
    go_d    = go;
    tx_d    = tx_q;
    rx_d    = rx_q;
    datao_d = datao_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    busy_d  = start || (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        sclk_d = CPOL;
        if (start) begin
          tx_d    = datai;
          rx_d    = '0;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          div_d   = clk_divider;
          cnt_d   = clk_divider;
          edge_d  = '0;
          if (!CPHA) dout_d = datai[DATA_WIDTH-1];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_n;
          if (leading) begin
            if (cpha_q) begin
              dout_d = tx_q[DATA_WIDTH-1];
              tx_d   = tx_q << 1;
            end else begin
              rx_d = {rx_q[DATA_WIDTH-2:0], din};
            end
          end else begin
            if (cpha_q) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], din};
            end else if (edge_n != LAST_EDGE) begin
              // CPHA=0 already shows the MSB, so the next bit is tx[MSB-1].
              dout_d = tx_q[DATA_WIDTH-2];
              tx_d   = tx_q << 1;
            end
          end
          if (edge_n == LAST_EDGE) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        sclk_d  = cpol_q;
        done_d  = 1'b1;
        datao_d = rx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      datao_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      datao_q <= datao_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign datao     = datao_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dout      = dout_q;
  assign sclk      = sclk_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: per-cycle observation of the SPI pins
// against hand-computed cycle numbers, data words and pulse widths.
module tb_spi_shift_engine;

  logic       clk;
  logic       rst;
  logic       cpol;
  logic       cpha;
  logic [7:0] clk_divider;
  logic       go;
  logic [7:0] datai;
  logic [7:0] datao;
  logic       busy;
  logic       done;
  logic       din;
  logic       dout;
  logic       sclk;
  logic [1:0] dbg_state;
  logic       loop_en;
  logic       din_drv;

  int n_checks;
  int n_errors;

  assign din = loop_en ? dout : din_drv;

  spi_shift_engine #(.DATA_WIDTH(8), .CLK_DIVIDER_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .CPOL        (cpol),
    .CPHA        (cpha),
    .clk_divider (clk_divider),
    .go          (go),
    .datai       (datai),
    .datao       (datao),
    .busy        (busy),
    .done        (done),
    .din         (din),
    .dout        (dout),
    .sclk        (sclk),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = drop go early, 1 = hold go throughout, 2 = disturb inputs mid-transfer
  task automatic run_xfer(input logic pol, input logic pha, input logic [7:0] n,
                          input logic [7:0] data, input logic [7:0] sword,
                          input logic loop, input int mode, input int extra,
                          input string tag);
    int         exp_done, ndone, done_cyc, lead_cnt, edge_cnt;
    int         width_bad, dout_bad, busy_last, last_toggle, idx;
    logic [7:0] datao_obs, mosi, exp_rx;
    logic       prev_sclk, prev_dout, lead, toggled;
    go = 1'b0;
    repeat (2) @(negedge clk);
    cpol = pol; cpha = pha; clk_divider = n; datai = data; loop_en = loop;
    din_drv = pha ? 1'b0 : sword[7];
    idx = pha ? 0 : 1;
    exp_done = 16 * (int'(n) + 1) + 1;
    exp_rx = loop ? data : sword;
    ndone = 0; done_cyc = -1; lead_cnt = 0; edge_cnt = 0;
    width_bad = 0; dout_bad = 0; busy_last = -1; last_toggle = 0;
    datao_obs = 8'h00; mosi = 8'h00; prev_sclk = 1'b0; prev_dout = 1'b0;
    go = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= exp_done + 2 + extra; c++) begin
      @(negedge clk);
      toggled = 1'b0;
      lead = 1'b0;
      if (c == 0) begin
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        check({tag, "_sclk0"}, 32'(sclk), 32'(pol));
        check({tag, "_state0"}, 32'(dbg_state), 32'd1);
        if (!pha) check({tag, "_dout0"}, 32'(dout), 32'(data[7]));
      end else if (busy) begin
        if (sclk !== prev_sclk) begin
          toggled = 1'b1;
          edge_cnt++;
          lead = (sclk != pol);
          if (lead) lead_cnt++;
          if (c - last_toggle != int'(n) + 1) width_bad++;
          last_toggle = c;
          if (lead != pha) mosi = {mosi[6:0], prev_dout};
          if (lead == pha && idx < 8) begin
            din_drv = sword[7 - idx];
            idx++;
          end
        end
        if (dout !== prev_dout && !(toggled && (lead == pha))) dout_bad++;
      end
      if (done) begin
        ndone++;
        done_cyc = c;
        datao_obs = datao;
      end
      if (busy) busy_last = c;
      if (mode == 0 && c == 2) go = 1'b0;
      if (mode == 2 && c == 5) begin
        datai = ~data; cpol = ~pol; clk_divider = n + 8'd2;
      end
      if (mode == 2 && c == 6) go = 1'b0;
      if (mode == 2 && c == 8) go = 1'b1;
      prev_sclk = sclk;
      prev_dout = dout;
    end
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_datao"}, 32'(datao_obs), 32'(exp_rx));
    check({tag, "_edges"}, 32'(edge_cnt), 32'd16);
    check({tag, "_pulses"}, 32'(lead_cnt), 32'd8);
    check({tag, "_width_bad"}, 32'(width_bad), 32'd0);
    check({tag, "_mosi"}, 32'(mosi), 32'(data));
    check({tag, "_dout_bad"}, 32'(dout_bad), 32'd0);
    check({tag, "_busy_last"}, 32'(busy_last), 32'(exp_done));
    if (mode != 2) check({tag, "_sclk_idle"}, 32'(sclk), 32'(pol));
    cpol = pol; clk_divider = n; datai = data;
  endtask

  initial begin
    int nd;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; go = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_divider = 8'd0;
    datai = 8'h00; loop_en = 1'b0; din_drv = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_datao", 32'(datao), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    run_xfer(1'b0, 1'b0, 8'd0, 8'hA5, 8'h00, 1'b1, 0, 0, "m0");
    run_xfer(1'b1, 1'b1, 8'd3, 8'h00, 8'hFF, 1'b0, 0, 0, "m3");
    run_xfer(1'b0, 1'b1, 8'd1, 8'hC3, 8'h3C, 1'b0, 0, 0, "m1");
    run_xfer(1'b1, 1'b0, 8'd2, 8'h81, 8'h7E, 1'b0, 0, 0, "m2");
    run_xfer(1'b0, 1'b0, 8'd0, 8'h33, 8'h00, 1'b1, 1, 200, "hold");
    run_xfer(1'b0, 1'b0, 8'd0, 8'h5A, 8'h00, 1'b1, 0, 0, "rearm");
    run_xfer(1'b0, 1'b0, 8'd1, 8'h69, 8'h00, 1'b1, 2, 0, "mid");

    // reset in the middle of a mode-0 transfer
    go = 1'b0;
    repeat (2) @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; clk_divider = 8'd0; datai = 8'hFF; loop_en = 1'b1;
    go = 1'b1;
    @(posedge clk);
    repeat (9) @(negedge clk);
    check("pre_rst_dout", 32'(dout), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_datao", 32'(datao), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    go = 1'b0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("post_rst_nodone", 32'(nd), 32'd0);
    run_xfer(1'b0, 1'b0, 8'd0, 8'h96, 8'h00, 1'b1, 0, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
